// File: rtl/xpb_accumulator.sv
// xpb_accumulator
//
// Carry-save accumulator placed directly after the xpb lookup tables in the
// modular squaring datapath. Each accepted WIDTH-bit term is folded into a
// redundant sum/carry pair with no carry propagation. After the term flagged
// last, the pair is resolved by a chunked carry-propagate add, one chunk per
// cycle, and the binary result is held on out_sum until downstream takes it.
//
// Ports
//   clk       rising-edge clock
//   reset     asynchronous, active-high reset
//   start     begin a new accumulation (honoured in idle only)
//   in_valid  in_data / in_last valid
//   in_ready  accumulator can take a term (registered)
//   in_data   xpb term, zero-extended to WIDTH+GUARD
//   in_last   final term of this accumulation
//   out_valid out_sum valid, held until taken (registered)
//   out_ready downstream accepts out_sum
//   out_sum   resolved sum of all accepted terms, modulo 2**(WIDTH+GUARD)
//   err       sticky: more than 2**GUARD terms were presented
module xpb_accumulator #(
    parameter int unsigned WIDTH      = 1024,
    parameter int unsigned GUARD      = 8,
    parameter int unsigned NUM_CHUNKS = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [WIDTH-1:0]       in_data,
    input  logic                   in_last,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [WIDTH+GUARD-1:0] out_sum,
    output logic                   err
);

    localparam int unsigned SW = WIDTH + GUARD;
    localparam int unsigned CW = SW / NUM_CHUNKS;
    localparam int unsigned KW = (NUM_CHUNKS > 1) ? $clog2(NUM_CHUNKS) : 1;

    // Term count saturates here; further terms are dropped and flag err.
    localparam logic [GUARD:0] MaxTerms  = {1'b1, {GUARD{1'b0}}};
    localparam logic [KW-1:0]  LastChunk = KW'(NUM_CHUNKS - 1);

    typedef enum logic [1:0] {
        StIdle,
        StAccum,
        StResolve,
        StDone
    } state_e;

    state_e         state_q, state_d;
    logic [SW-1:0]  sum_q, sum_d;
    logic [SW-1:0]  carry_q, carry_d;
    logic [SW-1:0]  out_sum_q, out_sum_d;
    logic [GUARD:0] count_q, count_d;
    logic [KW-1:0]  chunk_q, chunk_d;
    logic           cin_q, cin_d;
    logic           in_ready_q, in_ready_d;
    logic           out_valid_q, out_valid_d;
    logic           err_q, err_d;

    logic [SW-1:0]  term_ext;
    logic [31:0]    chunk_lo;
    logic [CW:0]    chunk_add;
    logic           accept;

    assign term_ext = {{GUARD{1'b0}}, in_data};
    assign accept   = in_valid && in_ready_q;

    // One slice of the carry-propagate add; the carry ripples between cycles
    // through cin_q.
    always_comb begin
        chunk_lo  = 32'(chunk_q) * CW;
        chunk_add = {1'b0, sum_q[chunk_lo +: CW]}
                  + {1'b0, carry_q[chunk_lo +: CW]}
                  + {{CW{1'b0}}, cin_q};
    end

    always_comb begin
        state_d   = state_q;
        sum_d     = sum_q;
        carry_d   = carry_q;
        out_sum_d = out_sum_q;
        count_d   = count_q;
        chunk_d   = chunk_q;
        cin_d     = cin_q;
        err_d     = err_q;

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    sum_d   = '0;
                    carry_d = '0;
                    count_d = '0;
                    err_d   = 1'b0;
                    state_d = StAccum;
                end
            end

            StAccum: begin
                if (accept) begin
                    if (count_q == MaxTerms) begin
                        err_d = 1'b1;
                    end else begin
                        sum_d   = sum_q ^ carry_q ^ term_ext;
                        // Majority shifted up one place; the bit leaving the
                        // top is a multiple of 2**SW and is dropped.
                        carry_d = ((sum_q & carry_q) | (sum_q & term_ext) |
                                   (carry_q & term_ext)) << 1;
                        count_d = count_q + 1'b1;
                    end
                    if (in_last) begin
                        chunk_d = '0;
                        cin_d   = 1'b0;
                        state_d = StResolve;
                    end
                end
            end

            StResolve: begin
                out_sum_d[chunk_lo +: CW] = chunk_add[CW-1:0];
                cin_d                     = chunk_add[CW];
                if (chunk_q == LastChunk) begin
                    state_d = StDone;
                end else begin
                    chunk_d = chunk_q + 1'b1;
                end
            end

            StDone: begin
                if (out_valid_q && out_ready) begin
                    state_d = StIdle;
                end
            end

            default: begin
                state_d = StIdle;
            end
        endcase

        // Handshake outputs are registered copies of the next-state decode.
        in_ready_d  = (state_d == StAccum);
        out_valid_d = (state_d == StDone);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= StIdle;
            sum_q       <= '0;
            carry_q     <= '0;
            out_sum_q   <= '0;
            count_q     <= '0;
            chunk_q     <= '0;
            cin_q       <= 1'b0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            sum_q       <= sum_d;
            carry_q     <= carry_d;
            out_sum_q   <= out_sum_d;
            count_q     <= count_d;
            chunk_q     <= chunk_d;
            cin_q       <= cin_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            err_q       <= err_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_sum   = out_sum_q;
    assign err       = err_q;

endmodule

// File: tb/tb_xpb_accumulator.sv
// Testbench for xpb_accumulator. Stimulus pushes the expected sum/err of each
// accumulation into a queue; an independent monitor pops and compares on every
// output handshake. Expected values come from plain integer addition of the
// accepted terms.
module tb_xpb_accumulator;

    localparam int unsigned WIDTH      = 1024;
    localparam int unsigned GUARD      = 8;
    localparam int unsigned NUM_CHUNKS = 4;
    localparam int unsigned SW         = WIDTH + GUARD;
    localparam int          MAX_TERMS  = 1 << GUARD;

    logic             clk       = 1'b0;
    logic             reset     = 1'b1;
    logic             start     = 1'b0;
    logic             in_valid  = 1'b0;
    logic             in_ready;
    logic [WIDTH-1:0] in_data   = '0;
    logic             in_last   = 1'b0;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [SW-1:0]    out_sum;
    logic             err;

    always #5 clk = ~clk;

    xpb_accumulator #(
        .WIDTH      (WIDTH),
        .GUARD      (GUARD),
        .NUM_CHUNKS (NUM_CHUNKS)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .err       (err)
    );

    int               n_checks = 0;
    int               n_pass   = 0;
    logic [SW-1:0]    exp_sum_q[$];
    bit               exp_err_q[$];
    int               pushed   = 0;
    int               popped   = 0;
    logic [WIDTH-1:0] terms[$];
    int               hold_low  = 0;
    bit               force_one = 1'b0;

    task automatic check(input string name, input logic [SW-1:0] act,
                         input logic [SW-1:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got hi=%h lo=%h, want hi=%h lo=%h", name,
                     act[SW-1:SW-32], act[95:0], exp[SW-1:SW-32], exp[95:0]);
        end
    endtask

    function automatic logic [WIDTH-1:0] rand_term();
        logic [WIDTH-1:0] t;
        int mode;
        mode = $urandom_range(0, 3);
        for (int i = 0; i < int'(WIDTH / 32); i++) t[i*32 +: 32] = $urandom;
        if (mode == 0) t = '1;
        if (mode == 1) t = WIDTH'($urandom_range(0, 255));
        return t;
    endfunction

    // Reference: the first 2**GUARD terms are summed, later ones only set err.
    function automatic void model(output logic [SW-1:0] s, output bit e);
        s = '0;
        e = 1'b0;
        for (int i = 0; i < terms.size(); i++) begin
            if (i < MAX_TERMS) s = s + {{GUARD{1'b0}}, terms[i]};
            else e = 1'b1;
        end
    endfunction

    // Output sink: random backpressure, or a forced stall of hold_low valid
    // cycles followed by exactly one ready cycle.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (hold_low > 0) begin
                out_ready = 1'b0;
                if (out_valid) begin
                    hold_low--;
                    if (hold_low == 0) force_one = 1'b1;
                end
            end else if (force_one) begin
                out_ready = 1'b1;
                force_one = 1'b0;
            end else begin
                out_ready = ($urandom_range(0, 3) != 0);
            end
        end
    end

    // Monitor
    initial begin
        logic [SW-1:0] held;
        bit            holding;
        bit            expect_drop;
        holding     = 1'b0;
        expect_drop = 1'b0;
        held        = '0;
        forever begin
            @(negedge clk);
            if (reset) begin
                holding     = 1'b0;
                expect_drop = 1'b0;
            end else begin
                if (expect_drop) begin
                    check("valid_drop_after_take", out_valid, 0);
                    expect_drop = 1'b0;
                end else if (holding && !out_valid) begin
                    check("valid_held_while_stalled", out_valid, 1);
                    holding = 1'b0;
                end
                if (out_valid) begin
                    if (holding) check("out_sum_stable", out_sum, held);
                    if (out_ready) begin
                        if (exp_sum_q.size() == 0) begin
                            n_checks++;
                            $display("FAIL unexpected_output: got lo=%h, want no output",
                                     out_sum[63:0]);
                        end else begin
                            check("out_sum", out_sum, exp_sum_q.pop_front());
                            check("out_err", err, exp_err_q.pop_front());
                            popped++;
                        end
                        holding     = 1'b0;
                        expect_drop = 1'b1;
                    end else begin
                        held    = out_sum;
                        holding = 1'b1;
                    end
                end
            end
        end
    end

    task automatic wait_drain();
        int n;
        n = 0;
        while (popped != pushed && n < 400) begin
            @(negedge clk);
            n++;
        end
        if (popped != pushed) check("drain_timeout", popped, pushed);
    endtask

    task automatic run(input bit push_exp, input bit gaps, input bit noise,
                       input bit mid_reset);
        logic [SW-1:0] es;
        bit            ee;
        int            lat;
        bit            got;
        wait_drain();
        @(posedge clk);
        #1;
        check("idle_in_ready", in_ready, 0);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        check("accum_in_ready", in_ready, 1);
        check("err_cleared_on_start", err, 0);
        if (push_exp) begin
            model(es, ee);
            exp_sum_q.push_back(es);
            exp_err_q.push_back(ee);
            pushed++;
        end
        for (int i = 0; i < terms.size(); i++) begin
            if (gaps) begin
                int g;
                g = $urandom_range(0, 2);
                for (int k = 0; k < g; k++) begin
                    in_valid = 1'b0;
                    in_data  = rand_term();
                    in_last  = 1'($urandom_range(0, 1));
                    if (noise) start = 1'($urandom_range(0, 1));
                    @(posedge clk);
                    #1;
                end
            end
            in_valid = 1'b1;
            in_data  = terms[i];
            in_last  = (i == terms.size() - 1);
            if (noise) start = 1'($urandom_range(0, 1));
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        start    = 1'b0;

        lat = 0;
        got = 1'b0;
        while (!got && lat < 4 * int'(NUM_CHUNKS) + 8) begin
            if (noise) begin
                start    = 1'($urandom_range(0, 1));
                in_valid = 1'($urandom_range(0, 1));
                in_data  = rand_term();
                in_last  = 1'($urandom_range(0, 1));
            end
            @(negedge clk);
            lat++;
            if (lat == 1) check("resolve_in_ready", in_ready, 0);
            if (mid_reset && lat == 2) begin
                reset = 1'b1;
                #1;
                check("rst_out_valid", out_valid, 0);
                check("rst_in_ready", in_ready, 0);
                check("rst_err", err, 0);
                check("rst_out_sum", out_sum, 0);
                @(negedge clk);
                reset    = 1'b0;
                start    = 1'b0;
                in_valid = 1'b0;
                in_last  = 1'b0;
                return;
            end
            if (out_valid) got = 1'b1;
        end
        check("latency", lat, NUM_CHUNKS + 1);

        in_last  = 1'b0;
        start    = noise;
        in_valid = noise;
        if (noise) begin
            int n;
            n = 0;
            // start stays high through the handshake cycle and must be ignored.
            while (out_valid && n < 200) begin
                @(negedge clk);
                n++;
            end
            start    = 1'b0;
            in_valid = 1'b0;
            check("done_taken", out_valid, 0);
            check("start_ignored_in_done", in_ready, 0);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        // Reset state
        reset = 1'b1;
        repeat (3) @(negedge clk);
        check("reset_out_valid", out_valid, 0);
        check("reset_in_ready", in_ready, 0);
        check("reset_err", err, 0);
        check("reset_out_sum", out_sum, 0);
        reset = 1'b0;

        // Single term of 1
        terms.delete();
        terms.push_back(WIDTH'(1));
        run(1'b1, 1'b0, 1'b0, 1'b0);

        // Two all-ones terms
        terms.delete();
        repeat (2) terms.push_back('1);
        run(1'b1, 1'b0, 1'b0, 1'b0);

        // Exactly the maximum term count, then one over
        terms.delete();
        repeat (MAX_TERMS) terms.push_back('1);
        run(1'b1, 1'b0, 1'b0, 1'b0);
        terms.push_back('1);
        run(1'b1, 1'b0, 1'b0, 1'b0);

        // Output held under a 10-cycle stall, then one ready cycle
        wait_drain();
        hold_low = 10;
        terms.delete();
        repeat (3) terms.push_back(rand_term());
        run(1'b1, 1'b0, 1'b0, 1'b0);
        wait_drain();
        check("stall_consumed", hold_low, 0);

        // Random terms with idle cycles and ignored start/in_valid noise
        for (int r = 0; r < 6; r++) begin
            int n;
            n = $urandom_range(1, 24);
            terms.delete();
            for (int i = 0; i < n; i++) terms.push_back(rand_term());
            run(1'b1, 1'b1, 1'b1, 1'b0);
        end
        terms.delete();
        repeat (40) terms.push_back(rand_term());
        run(1'b1, 1'b0, 1'b0, 1'b0);

        // Reset mid-resolve with err set, then a fresh accumulation of 5
        terms.delete();
        repeat (MAX_TERMS + 1) terms.push_back('1);
        run(1'b0, 1'b0, 1'b0, 1'b1);
        terms.delete();
        terms.push_back(WIDTH'(5));
        run(1'b1, 1'b0, 1'b0, 1'b0);

        wait_drain();
        repeat (3) @(negedge clk);
        check("queue_empty", exp_sum_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
